// File: rtl/gio_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : gio_debouncer
//  Description : Eight independent switch/key debouncers. Each raw pin is
//                optionally inverted, synchronized through two flops, and
//                accepted as a new stable level only after it has disagreed
//                with the current stable level for DEBOUNCE_CYCLES
//                consecutive clocks. Registered press/release strobes and a
//                CPU-clearable sticky press record are derived from the
//                stable levels.
//  Revision    : 1.0 - initial release
// ============================================================================
module gio_debouncer #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20,
    parameter logic [7:0]  ACTIVE_LOW_MASK = 8'h00
) (
    input  logic        clk,
    input  logic        reset,          // synchronous, active low
    input  logic [7:0]  raw_pins,
    input  logic [7:0]  clear_events,
    output logic [7:0]  GIO_pins,
    output logic [7:0]  press_pulse,
    output logic [7:0]  release_pulse,
    output logic [7:0]  press_latch
);

    // Terminal count: the last value the counter may hold before the new
    // level is accepted. Sized to the counter so the compare is width-exact.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] w_stable;
    logic [7:0] w_rise;
    logic [7:0] w_fall;
    logic [7:0] r_gio;
    logic [7:0] r_press;
    logic [7:0] r_release;
    logic [7:0] r_latch;

    // Two-flop synchronizer; polarity is normalized before the first flop
    // so that every later stage sees "1 = pressed".
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= raw_pins ^ ACTIVE_LOW_MASK;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            // Per-channel qualification counter: any agreement with the
            // stable level discards the partial count; reaching the terminal
            // count while still disagreeing commits the new level.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync2[gi] == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync2[gi];
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            end

            assign w_stable[gi] = r_stable;
        end
    endgenerate

    // Edges of the stable level, measured against the previously published
    // level so the published level and its strobe appear on the same cycle.
    assign w_rise = w_stable & ~r_gio;
    assign w_fall = ~w_stable & r_gio;

    // Output stage: published levels, one-cycle strobes, and the sticky
    // press record where a new press outranks a coincident CPU clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gio     <= 8'h00;
            r_press   <= 8'h00;
            r_release <= 8'h00;
            r_latch   <= 8'h00;
        end else begin
            r_gio     <= w_stable;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_latch   <= (r_latch & ~clear_events) | w_rise;
        end
    end

    assign GIO_pins      = r_gio;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_latch   = r_latch;

endmodule
`default_nettype wire

// File: tb/tb_gio_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gio_debouncer
//  Description : Directed self-checking bench for gio_debouncer with
//                DEBOUNCE_CYCLES=4. A second instance with one inverted
//                channel is driven with the complementary pin so both must
//                behave identically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gio_debouncer;

    logic       clk;
    logic       reset;
    logic [7:0] raw;
    logic [7:0] clr;
    logic [7:0] gio,  pp,  rp,  pl;
    logic [7:0] gio2, pp2, rp2, pl2;
    logic [7:0] raw2;

    int n_cmp;
    int n_err;

    assign raw2 = raw ^ 8'h04;

    gio_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4),
        .ACTIVE_LOW_MASK (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_pins      (raw),
        .clear_events  (clr),
        .GIO_pins      (gio),
        .press_pulse   (pp),
        .release_pulse (rp),
        .press_latch   (pl)
    );

    gio_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4),
        .ACTIVE_LOW_MASK (8'h04)
    ) dut_inv (
        .clk           (clk),
        .reset         (reset),
        .raw_pins      (raw2),
        .clear_events  (clr),
        .GIO_pins      (gio2),
        .press_pulse   (pp2),
        .release_pulse (rp2),
        .press_latch   (pl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {GIO_pins, press_pulse, release_pulse, press_latch}.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        raw   = 8'hFF;
        clr   = 8'hFF;

        // Reset hold with all inputs high: every output stays zero.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("reset_hold", {gio, pp, rp, pl}, 32'h0);
            chk("reset_hold_inv", {gio2, pp2, rp2, pl2}, 32'h0);
        end

        raw = 8'h00;
        clr = 8'h00;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("idle", {gio, pp, rp, pl}, 32'h0);

        // Clean press on channel 0: visible after the 7th edge from the change.
        raw = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("press_wait", {gio, pp, rp, pl}, 32'h0);
        end
        tick();
        chk("press_edge", {gio, pp, rp, pl}, {8'h01, 8'h01, 8'h00, 8'h01});
        tick();
        chk("press_after", {gio, pp, rp, pl}, {8'h01, 8'h00, 8'h00, 8'h01});

        // Release of channel 0.
        raw = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("release_wait", {gio, pp, rp, pl}, {8'h01, 8'h00, 8'h00, 8'h01});
        end
        tick();
        chk("release_edge", {gio, pp, rp, pl}, {8'h00, 8'h00, 8'h01, 8'h01});
        tick();
        chk("release_after", {gio, pp, rp, pl}, {8'h00, 8'h00, 8'h00, 8'h01});

        // CPU clear of the sticky record.
        clr = 8'h01;
        tick();
        chk("latch_clear", {gio, pp, rp, pl}, 32'h0);
        clr = 8'h00;

        // Bounce on channel 1: toggle every 2 cycles, never long enough.
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) raw[1] = ~raw[1];
            tick();
            chk("bounce", {gio, pp, rp, pl}, 32'h0);
        end
        raw = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bounce_hold", {gio, pp, rp, pl}, 32'h0);
        end

        // All channels in parallel.
        raw = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("par_wait", {gio, pp, rp, pl}, 32'h0);
        end
        tick();
        chk("par_edge", {gio, pp, rp, pl}, {8'hA5, 8'hA5, 8'h00, 8'hA5});
        chk("par_edge_inv", {gio2, pp2, rp2, pl2}, {8'hA5, 8'hA5, 8'h00, 8'hA5});
        tick();
        chk("par_after", {gio, pp, rp, pl}, {8'hA5, 8'h00, 8'h00, 8'hA5});
        raw = 8'h00;
        for (int k = 1; k <= 6; k++) tick();
        tick();
        chk("par_release", {gio, pp, rp, pl}, {8'h00, 8'h00, 8'hA5, 8'hA5});
        clr = 8'hFF;
        tick();
        clr = 8'h00;
        chk("par_clear", {gio, pp, rp, pl}, 32'h0);

        // Set outranks a coincident clear, then the held clear takes over.
        clr = 8'h01;
        raw = 8'h01;
        for (int k = 1; k <= 6; k++) tick();
        tick();
        chk("prio_set", {gio, pp, rp, pl}, {8'h01, 8'h01, 8'h00, 8'h01});
        tick();
        chk("prio_clear", {gio, pp, rp, pl}, {8'h01, 8'h00, 8'h00, 8'h00});
        clr = 8'h00;
        raw = 8'h00;
        for (int k = 0; k < 8; k++) tick();
        chk("prio_idle", {gio, pp, rp, pl}, 32'h0);

        // Mid-count reset on channel 2 (counter at 2 after four edges).
        raw = 8'h04;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b0;
        tick();
        chk("midrst", {gio, pp, rp, pl}, 32'h0);
        chk("midrst_inv", {gio2, pp2, rp2, pl2}, 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("midrst_wait", {gio, pp, rp, pl}, 32'h0);
            chk("midrst_wait_inv", {gio2, pp2, rp2, pl2}, 32'h0);
        end
        tick();
        chk("midrst_press", {gio, pp, rp, pl}, {8'h04, 8'h04, 8'h00, 8'h04});
        chk("midrst_press_inv", {gio2, pp2, rp2, pl2}, {8'h04, 8'h04, 8'h00, 8'h04});
        tick();
        chk("midrst_after", {gio, pp, rp, pl}, {8'h04, 8'h00, 8'h00, 8'h04});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
